// File: rtl/decode_issue_queue_pkg.sv
// Shared constants for the decode-to-issue decoupling queue.
// The payload is packed locally by the top level, so this package adds no typedefs.
package decode_issue_queue_pkg;
  localparam int unsigned DECODE_Q_DEPTH = 4;
  localparam int unsigned SB_ENTRY_W     = 128;
  localparam int unsigned ORIG_INSTR_W   = 32;
endpackage

// File: rtl/decode_issue_fifo.sv
// Circular-buffer storage for the decode issue queue. A count register tracks
// full/empty, and the pointers wrap modulo DEPTH. clr_i overrides every other operation.
module decode_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 161
) (
  input  logic                         clk_i,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 wdata_i,
  output logic [W-1:0]                 rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_i)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; a dropped push simply does not write.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem[wr_ptr] <= wdata_i;
  end

  assign rdata_o = mem[rd_ptr];
  assign count_o = count;

endmodule

// File: rtl/decode_issue_queue.sv
// Decoupling queue between decode and issue (port 0). It also holds the last
// acknowledged entry, which the fusion logic compares against the current head.
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = DECODE_Q_DEPTH,
  parameter int unsigned ENTRY_W = SB_ENTRY_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic [ENTRY_W-1:0]          decoded_instr_i,
  input  logic [ORIG_INSTR_W-1:0]     orig_instr_i,
  input  logic                        is_ctrl_flow_i,
  input  logic                        decoded_instr_valid_i,
  output logic                        decoded_instr_ready_o,
  output logic [ENTRY_W-1:0]          decoded_instr_o,
  output logic [ORIG_INSTR_W-1:0]     orig_instr_o,
  output logic                        is_ctrl_flow_o,
  output logic                        decoded_instr_valid_o,
  input  logic                        decoded_instr_ack_i,
  output logic [ENTRY_W-1:0]          decoded_instr_prev_o,
  output logic                        prev_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o
);

  localparam int unsigned W     = ENTRY_W + ORIG_INSTR_W + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]       wdata;
  logic [W-1:0]       rdata;
  logic [W-1:0]       head;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic               clr;
  logic [ENTRY_W-1:0] prev_entry;
  logic               prev_valid;

  // Handshakes depend only on the registered count, so there is no ack-to-ready path.
  assign decoded_instr_ready_o = (count != CNT_W'(DEPTH));
  assign decoded_instr_valid_o = (count != '0);
  assign push  = decoded_instr_valid_i & decoded_instr_ready_o;
  assign pop   = decoded_instr_ack_i & decoded_instr_valid_o;
  assign clr   = rst_i | flush_i;
  assign wdata = {is_ctrl_flow_i, orig_instr_i, decoded_instr_i};

  decode_issue_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) i_fifo (
    .clk_i   (clk_i),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .count_o (count)
  );

  // An empty queue presents zeros instead of stale storage.
  assign head            = decoded_instr_valid_o ? rdata : '0;
  assign decoded_instr_o = head[ENTRY_W-1:0];
  assign orig_instr_o    = head[ENTRY_W +: ORIG_INSTR_W];
  assign is_ctrl_flow_o  = head[W-1];
  assign count_o         = count;

  // No fusion across a control-flow boundary, so a popped branch invalidates prev.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_entry <= '0;
      prev_valid <= 1'b0;
    end else if (flush_i) begin
      prev_valid <= 1'b0;
    end else if (pop) begin
      prev_entry <= decoded_instr_o;
      prev_valid <= ~is_ctrl_flow_o;
    end
  end

  assign decoded_instr_prev_o = prev_entry;
  assign prev_valid_o         = prev_valid;

endmodule

// File: doc/decode_issue_queue.md
# decode_issue_queue

Decoupling queue between the decode stage and the issue stage. Decoded scoreboard entries are buffered here so decode stalls do not ripple upstream on every issue hold-off. The block also supplies the issue stage with the most recently issued entry (`decoded_instr_prev_o`), which the fusion logic compares against the current head to detect fusible pairs. Sits directly upstream of `issue_stage`, port 0 only.

## Interface
Parameters:
- `DEPTH`, default 4 — queue entries; power of two, at least 2.
- `ENTRY_W`, default 128 — width of one packed `scoreboard_entry_t`.

Ports:
- `clk_i` in 1 — clock.
- `rst_i` in 1 — reset, synchronous, active-high.
- `flush_i` in 1 — drop all queued entries and invalidate the prev register.
- `decoded_instr_i` in ENTRY_W — entry from decode.
- `orig_instr_i` in 32 — raw instruction bits.
- `is_ctrl_flow_i` in 1 — entry is a branch, jump or return.
- `decoded_instr_valid_i` in 1 — decode offers an entry.
- `decoded_instr_ready_o` out 1 — queue accepts the entry.
- `decoded_instr_o` out ENTRY_W — head entry.
- `orig_instr_o` out 32 — head raw bits.
- `is_ctrl_flow_o` out 1 — head control-flow flag.
- `decoded_instr_valid_o` out 1 — head is valid.
- `decoded_instr_ack_i` in 1 — issue stage consumed the head.
- `decoded_instr_prev_o` out ENTRY_W — last acknowledged entry.
- `prev_valid_o` out 1 — `decoded_instr_prev_o` is usable for fusion.
- `count_o` out $clog2(DEPTH+1) — occupancy.

## Operation
- **Push**: `decoded_instr_valid_i & decoded_instr_ready_o`.
  - `decoded_instr_ready_o = (count != DEPTH)`. It depends only on registered count and has no combinational path from `ack_i`.
- **Pop**: `decoded_instr_ack_i & decoded_instr_valid_o`.
  - `decoded_instr_valid_o = (count != 0)`.
  - An ack while the queue is empty is ignored.
- **Prev register update on pop**:
  - `prev <= head`.
  - `prev_valid <= ~head.is_ctrl_flow`. No fusion across a control-flow boundary.
- **Pointers**: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The count register tracks full/empty; no extra wrap bit.
- **Simultaneous push and pop**: count is unchanged and both pointers advance.
  - Push while full is impossible because ready=0.
  - Push and pop at count==1 is legal; the new entry becomes head next cycle.
- **No bypass**: an entry pushed into an empty queue is visible at the head on the next cycle.
- **Flush**:
  - Effect: count←0, both pointers←0, `prev_valid`←0.
  - Priority: highest. A same-cycle push is dropped and a same-cycle pop does not update prev.
  - Storage contents are not cleared.
- **Reset** (`rst_i`): same effect as flush. Also clears `decoded_instr_prev_o` to 0.
  - Reset values: `ready_o`=1, `valid_o`=0, `prev_valid_o`=0, `count_o`=0, `decoded_instr_prev_o`=0.
  - Head data outputs are don't-care while `valid_o`=0 and are driven as 0 after reset.
  - A reset asserted mid-operation takes effect at the next edge regardless of any handshake.

## Timing
- Push to head visible: 1 cycle minimum.
- Pop to prev visible: 1 cycle.
- Throughput: 1 entry per cycle when not full.
- All outputs are registered, or combinational only from registered state (read mux on the head pointer).
- Flush: valid drops and ready rises on the cycle after `flush_i`.

## Structure
- Entry storage and pointer logic go in sub-module `decode_issue_fifo` (parameters DEPTH, W). Its payload is `{ctrl_flow, orig_instr, entry}`, W = ENTRY_W+33.
- Top level holds the prev register, prev_valid, and the flush/reset priority.
- `DECODE_Q_DEPTH` is added to `ariane_pkg` as a localparam; the top-level instance passes it as DEPTH.
- No new typedefs. The payload is packed locally.

## Test plan
- **Fill to full**: push 4 entries A–D with ack=0.
  - count goes 1,2,3,4; ready=0 at count 4.
  - A 5th push is refused and head stays A.
- **Streaming**: valid_i=1 and ack=1 every cycle over 8 entries.
  - Count stays 1 after the first cycle.
  - Output order equals input order.
  - prev trails head by one entry.
- **Control-flow break**: ack a head with `is_ctrl_flow`=1.
  - Next cycle `prev_valid_o`=0.
  - After acking a following ALU entry, `prev_valid_o`=1 and `prev_o` equals that ALU entry.
- **Wrap-around**: interleave 3 pushes, 2 pops, 3 pushes, 4 pops with DEPTH=4.
  - FIFO order is preserved across the pointer wrap.
  - count ends at 0.
- **Flush with simultaneous push and ack** at count=3: same cycle as flush.
  - Next cycle count=0, valid=0, prev_valid=0.
  - The pushed entry never appears at the head.
- **Reset mid-stream** at count=2 with prev_valid=1: all outputs return to their reset values on the next cycle.
